// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back source encodings, load/store size codes
// and the MEM-stage FSM states.
package pipe_pkg;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DRAM = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;
    localparam logic [1:0] WD_SEXT = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WAIT} state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane logic: store strobes and replicated write data,
// load lane extraction with sign/zero extension, and the alignment check.
module lsu_align
    import pipe_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic        aligned_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    assign byteLane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign halfLane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Unsupported size codes fall to default and are reported as misaligned.
    always_comb begin
        aligned_o   = 1'b0;
        wstrb_o     = 4'b0000;
        wdata_o     = store_data_i;
        load_data_o = 32'h0;
        case (funct3_i)
            F3_B, F3_BU: begin
                aligned_o   = 1'b1;
                wstrb_o     = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = (funct3_i == F3_B) ? {{24{byteLane[7]}}, byteLane}
                                                 : {24'h0, byteLane};
            end
            F3_H, F3_HU: begin
                aligned_o   = ~addr_lo_i[0];
                wstrb_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = (funct3_i == F3_H) ? {{16{halfLane[15]}}, halfLane}
                                                 : {16'h0, halfLane};
            end
            F3_W: begin
                aligned_o   = (addr_lo_i == 2'b00);
                wstrb_o     = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = rdata_i;
            end
            default: begin
                aligned_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage of the RV32I pipeline: DRAM handshake FSM with timeout, upstream
// stall generation, and the MEM/WB pipeline register feeding register-file writes.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_mem,
    input  logic        rf_we_mem,
    input  logic [1:0]  wd_sel_mem,
    input  logic [4:0]  wR_mem,
    input  logic [31:0] alu_c_mem,
    input  logic [31:0] rD2_mem,
    input  logic [31:0] pc_mem,
    input  logic [31:0] sext_mem,
    input  logic        mem_re_mem,
    input  logic        mem_we_mem,
    input  logic [2:0]  funct3_mem,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic [3:0]  dram_wstrb,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata,
    output logic        stall_mem,
    output logic        rf_we_wb,
    output logic [1:0]  wd_sel_wb,
    output logic [4:0]  wR_wb,
    output logic [31:0] alu_c_wb,
    output logic [31:0] pc_wb,
    output logic [31:0] sext_wb,
    output logic [31:0] dram_rd_wb,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        rfWe_q, rfWe_d;
    logic [1:0]  wdSel_q, wdSel_d;
    logic [4:0]  wR_q, wR_d;
    logic [31:0] aluC_q, aluC_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] sext_q, sext_d;
    logic [31:0] dramRd_q, dramRd_d;
    logic        misErr_q, misErr_d;
    logic        busErr_q, busErr_d;

    logic        memOp, isStore, isLoad, aligned, acc;
    logic        reqRaw, stallRaw, done, abort;
    logic [3:0]  laneStrb;
    logic [31:0] laneWdata, loadData;

    assign memOp   = mem_re_mem | mem_we_mem;
    assign isStore = mem_we_mem;
    assign isLoad  = mem_re_mem & ~mem_we_mem;
    assign acc     = valid_mem & memOp & aligned;

    lsu_align u_lsu_align (
        .funct3_i     (funct3_mem),
        .addr_lo_i    (alu_c_mem[1:0]),
        .store_data_i (rD2_mem),
        .rdata_i      (dram_rdata),
        .aligned_o    (aligned),
        .wstrb_o      (laneStrb),
        .wdata_o      (laneWdata),
        .load_data_o  (loadData)
    );

    // Handshake control; an ack in the final wait cycle wins over the timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reqRaw   = 1'b0;
        stallRaw = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        misErr_d = 1'b0;
        busErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                misErr_d = valid_mem & memOp & ~aligned;
                if (acc) begin
                    reqRaw = 1'b1;
                    if (dram_ack) begin
                        done = 1'b1;
                    end else begin
                        stallRaw = 1'b1;
                        state_d  = WAIT;
                        cnt_d    = '0;
                    end
                end
            end
            WAIT: begin
                reqRaw = 1'b1;
                if (dram_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    abort    = 1'b1;
                    busErr_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    stallRaw = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Stalled cycles load an all-zero bubble so the held instruction writes the RF once.
    always_comb begin
        rfWe_d   = 1'b0;
        wdSel_d  = 2'b00;
        wR_d     = 5'd0;
        aluC_d   = 32'h0;
        pc_d     = 32'h0;
        sext_d   = 32'h0;
        dramRd_d = 32'h0;
        if (!stallRaw) begin
            rfWe_d   = valid_mem & rf_we_mem & ~(memOp & ~aligned) & ~abort;
            wdSel_d  = wd_sel_mem;
            wR_d     = wR_mem;
            aluC_d   = alu_c_mem;
            pc_d     = pc_mem;
            sext_d   = sext_mem;
            dramRd_d = (done & isLoad) ? loadData : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rfWe_q   <= 1'b0;
            wdSel_q  <= 2'b00;
            wR_q     <= 5'd0;
            aluC_q   <= 32'h0;
            pc_q     <= 32'h0;
            sext_q   <= 32'h0;
            dramRd_q <= 32'h0;
            misErr_q <= 1'b0;
            busErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rfWe_q   <= rfWe_d;
            wdSel_q  <= wdSel_d;
            wR_q     <= wR_d;
            aluC_q   <= aluC_d;
            pc_q     <= pc_d;
            sext_q   <= sext_d;
            dramRd_q <= dramRd_d;
            misErr_q <= misErr_d;
            busErr_q <= busErr_d;
        end
    end

    // Combinational handshake outputs are forced quiet while reset is held.
    assign dram_req   = rst_n & reqRaw;
    assign stall_mem  = rst_n & stallRaw;
    assign dram_we    = dram_req & isStore;
    assign dram_addr  = dram_req ? {alu_c_mem[31:2], 2'b00} : 32'h0;
    assign dram_wdata = dram_we ? laneWdata : 32'h0;
    assign dram_wstrb = dram_we ? laneStrb : 4'b0000;

    assign rf_we_wb     = rfWe_q;
    assign wd_sel_wb    = wdSel_q;
    assign wR_wb        = wR_q;
    assign alu_c_wb     = aluC_q;
    assign pc_wb        = pc_q;
    assign sext_wb      = sext_q;
    assign dram_rd_wb   = dramRd_q;
    assign misalign_err = misErr_q;
    assign bus_err      = busErr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: constant vector table, hand-written
// multi-cycle sequences, and randomized operations against a size/offset model.
module tb_mem_wb_stage;
    import pipe_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_mem, rf_we_mem, mem_re_mem, mem_we_mem;
    logic [1:0]  wd_sel_mem;
    logic [4:0]  wR_mem;
    logic [31:0] alu_c_mem, rD2_mem, pc_mem, sext_mem;
    logic [2:0]  funct3_mem;
    logic        dram_req, dram_we, dram_ack;
    logic [31:0] dram_addr, dram_wdata, dram_rdata;
    logic [3:0]  dram_wstrb;
    logic        stall_mem, rf_we_wb, misalign_err, bus_err;
    logic [1:0]  wd_sel_wb;
    logic [4:0]  wR_wb;
    logic [31:0] alu_c_wb, pc_wb, sext_wb, dram_rd_wb;

    int checks = 0;
    int failures = 0;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem), .rf_we_mem(rf_we_mem),
        .wd_sel_mem(wd_sel_mem), .wR_mem(wR_mem), .alu_c_mem(alu_c_mem),
        .rD2_mem(rD2_mem), .pc_mem(pc_mem), .sext_mem(sext_mem),
        .mem_re_mem(mem_re_mem), .mem_we_mem(mem_we_mem), .funct3_mem(funct3_mem),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wstrb(dram_wstrb), .dram_ack(dram_ack),
        .dram_rdata(dram_rdata), .stall_mem(stall_mem), .rf_we_wb(rf_we_wb),
        .wd_sel_wb(wd_sel_wb), .wR_wb(wR_wb), .alu_c_wb(alu_c_wb), .pc_wb(pc_wb),
        .sext_wb(sext_wb), .dram_rd_wb(dram_rd_wb), .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rfwe, re, we;
        logic [2:0]  f3;
        logic [31:0] addr, rd2, rdata;
        logic        expReq, expWe;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        logic        expRfWe;
        logic [31:0] expRd;
        logic        expMis;
    } vec_t;

    vec_t tbl[15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rfwe, input logic re, input logic we,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rd2, input logic [31:0] rdata, input logic ack);
        valid_mem  = v;
        rf_we_mem  = rfwe;
        mem_re_mem = re;
        mem_we_mem = we;
        funct3_mem = f3;
        alu_c_mem  = addr;
        rD2_mem    = rd2;
        dram_rdata = rdata;
        dram_ack   = ack;
        wR_mem     = addr[6:2];
        pc_mem     = addr + 32'h1000;
        sext_mem   = ~addr;
        wd_sel_mem = re ? WD_DRAM : WD_ALU;
    endtask

    // Reference model: access size in bytes from funct3, 0 for unsupported codes.
    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit isAligned(input logic [2:0] f3, input logic [31:0] addr);
        int s = sizeOf(f3);
        return (s != 0) && ((addr % s) == 0);
    endfunction

    function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int s = sizeOf(f3);
        int off = int'(addr % 4);
        longint v = longint'({32'h0, rdata});
        v = (v >> (8 * off)) & ((longint'(1) << (8 * s)) - 1);
        if (f3[2] == 1'b0 && s < 4 && v >= (longint'(1) << (8 * s - 1)))
            v = v - (longint'(1) << (8 * s));
        return v[31:0];
    endfunction

    function automatic logic [3:0] strbModel(input logic [2:0] f3, input logic [31:0] addr);
        int s = sizeOf(f3);
        int off = int'(addr % 4);
        int m = ((1 << s) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] wdataModel(input logic [2:0] f3, input logic [31:0] rd2);
        int s = sizeOf(f3);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = rd2[8*(i % s) +: 8];
        return r;
    endfunction

    // One complete operation with the ack arriving ackDelay cycles after the first request.
    task automatic runOp(input logic v, input logic rfwe, input logic re, input logic we,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd2,
                         input logic [31:0] rdata, input int ackDelay, input logic spurious);
        bit memop = re | we;
        bit ok    = v && memop && isAligned(f3, addr);
        bit mis   = v && memop && !isAligned(f3, addr);
        bit tout  = ok && (ackDelay > TO);
        int endc  = ok ? ((ackDelay <= TO) ? ackDelay : TO) : 0;
        applyStimulus(v, rfwe, re, we, f3, addr, rd2, rdata, ok ? (ackDelay == 0) : spurious);
        for (int c = 0; c <= endc; c++) begin
            if (ok) dram_ack = (c == ackDelay);
            @(negedge clk);
            checkOutput("op_stall", 32'(stall_mem), 32'(c < endc));
            checkOutput("op_req", 32'(dram_req), 32'(ok));
            if (c == 0 && ok) begin
                checkOutput("op_addr", dram_addr, addr & 32'hFFFF_FFFC);
                checkOutput("op_we", 32'(dram_we), 32'(we));
                checkOutput("op_strb", 32'(dram_wstrb), we ? 32'(strbModel(f3, addr)) : 32'h0);
                checkOutput("op_wdata", dram_wdata, we ? wdataModel(f3, rd2) : 32'h0);
            end
            @(posedge clk);
            #1;
            if (c < endc) checkOutput("op_bubble_rfwe", 32'(rf_we_wb), 32'h0);
        end
        dram_ack = 1'b0;
        checkOutput("op_rfwe", 32'(rf_we_wb), 32'(v && rfwe && !mis && !tout));
        checkOutput("op_rd", dram_rd_wb, (ok && !tout && re && !we) ? loadModel(f3, addr, rdata) : 32'h0);
        checkOutput("op_mis", 32'(misalign_err), 32'(mis));
        checkOutput("op_buserr", 32'(bus_err), 32'(tout));
        checkOutput("op_aluc", alu_c_wb, addr);
        checkOutput("op_wr", 32'(wR_wb), 32'(addr[6:2]));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 1, 32'h0, 0};
        tbl[1]  = '{1, 0, 0, 1, 3'b001, 32'h202, 32'hABCD1234, 32'h0, 1, 1, 4'hC, 32'h12341234, 0, 32'h0, 0};
        tbl[2]  = '{1, 0, 0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1, 1, 4'h2, 32'hA5A5A5A5, 0, 32'h0, 0};
        tbl[3]  = '{1, 0, 0, 1, 3'b010, 32'h200, 32'hDEADBEEF, 32'h0, 1, 1, 4'hF, 32'hDEADBEEF, 0, 32'h0, 0};
        tbl[4]  = '{1, 1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0, 4'h0, 32'h0, 1, 32'hFFFFFF80, 0};
        tbl[5]  = '{1, 1, 1, 0, 3'b100, 32'h102, 32'h0, 32'h12A55678, 1, 0, 4'h0, 32'h0, 1, 32'h000000A5, 0};
        tbl[6]  = '{1, 1, 1, 0, 3'b001, 32'h002, 32'h0, 32'h80011234, 1, 0, 4'h0, 32'h0, 1, 32'hFFFF8001, 0};
        tbl[7]  = '{1, 1, 1, 0, 3'b101, 32'h000, 32'h0, 32'h8001F00D, 1, 0, 4'h0, 32'h0, 1, 32'h0000F00D, 0};
        tbl[8]  = '{1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 1, 0, 4'h0, 32'h0, 1, 32'hCAFEF00D, 0};
        tbl[9]  = '{1, 1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h11111111, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1};
        tbl[10] = '{1, 1, 1, 0, 3'b001, 32'h003, 32'h0, 32'h11111111, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1};
        tbl[11] = '{1, 1, 1, 0, 3'b011, 32'h100, 32'h0, 32'h11111111, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1};
        tbl[12] = '{0, 1, 1, 0, 3'b010, 32'h100, 32'h0, 32'h22222222, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0};
        tbl[13] = '{1, 0, 1, 1, 3'b010, 32'h300, 32'h11223344, 32'h55555555, 1, 1, 4'hF, 32'h11223344, 0, 32'h0, 0};
        tbl[14] = '{1, 0, 0, 1, 3'b001, 32'h200, 32'h0000BEEF, 32'h0, 1, 1, 4'h3, 32'hBEEFBEEF, 0, 32'h0, 0};

        // Reset state with a live load presented on the inputs.
        rst_n = 1'b0;
        applyStimulus(1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        #12;
        checkOutput("rst_req", 32'(dram_req), 32'h0);
        checkOutput("rst_stall", 32'(stall_mem), 32'h0);
        checkOutput("rst_rfwe", 32'(rf_we_wb), 32'h0);
        checkOutput("rst_aluc", alu_c_wb, 32'h0);
        checkOutput("rst_rd", dram_rd_wb, 32'h0);
        checkOutput("rst_pc", pc_wb, 32'h0);
        checkOutput("rst_err", 32'({misalign_err, bus_err}), 32'h0);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle vectors, memory accesses acknowledged in the request cycle.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].v, tbl[i].rfwe, tbl[i].re, tbl[i].we, tbl[i].f3,
                          tbl[i].addr, tbl[i].rd2, tbl[i].rdata, 1'b1);
            @(negedge clk);
            checkOutput("vec_req", 32'(dram_req), 32'(tbl[i].expReq));
            checkOutput("vec_we", 32'(dram_we), 32'(tbl[i].expWe));
            checkOutput("vec_strb", 32'(dram_wstrb), 32'(tbl[i].expStrb));
            checkOutput("vec_wdata", dram_wdata, tbl[i].expWdata);
            checkOutput("vec_addr", dram_addr, tbl[i].expReq ? (tbl[i].addr & 32'hFFFF_FFFC) : 32'h0);
            checkOutput("vec_stall", 32'(stall_mem), 32'h0);
            @(posedge clk);
            #1;
            checkOutput("vec_rfwe", 32'(rf_we_wb), 32'(tbl[i].expRfWe));
            checkOutput("vec_rd", dram_rd_wb, tbl[i].expRd);
            checkOutput("vec_mis", 32'(misalign_err), 32'(tbl[i].expMis));
            checkOutput("vec_aluc", alu_c_wb, tbl[i].addr);
            checkOutput("vec_buserr", 32'(bus_err), 32'h0);
        end
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        checkOutput("mis_pulse_end", 32'(misalign_err), 32'h0);

        // LB with ack two cycles after the request: two stalls, one RF write.
        runOp(1, 1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 2, 0);
        checkOutput("lb_wait_rd", dram_rd_wb, 32'hFFFFFF80);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        checkOutput("lb_single_write", 32'(rf_we_wb), 32'h0);

        // LW never acknowledged: four stall cycles then a bus error.
        runOp(1, 1, 1, 0, 3'b010, 32'h104, 32'h0, 32'h0, 99, 0);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        checkOutput("tout_idle_req", 32'(dram_req), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("tout_pulse_end", 32'(bus_err), 32'h0);

        // Reset asserted while waiting on DRAM, then a fresh LHU.
        applyStimulus(1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_req", 32'(dram_req), 32'h0);
        checkOutput("rstw_stall", 32'(stall_mem), 32'h0);
        checkOutput("rstw_we", 32'({dram_we, dram_wstrb}), 32'h0);
        checkOutput("rstw_rfwe", 32'(rf_we_wb), 32'h0);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstw_idle_req", 32'(dram_req), 32'h0);
        checkOutput("rstw_idle_stall", 32'(stall_mem), 32'h0);
        @(posedge clk);
        #1;
        runOp(1, 1, 1, 0, 3'b101, 32'h002, 32'h0, 32'h80015555, 0, 0);
        checkOutput("rstw_lhu", dram_rd_wb, 32'h00008001);

        // Randomized operations, including spurious acks on non-accesses and timeouts.
        for (int n = 0; n < 300; n++) begin
            logic        v, rfwe, re, we, sp;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          sel;
            v    = ($urandom_range(0, 7) != 0);
            rfwe = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 3);
            re   = (sel == 1) || (sel == 3);
            we   = (sel == 2) || (sel == 3);
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            sp   = 1'($urandom_range(0, 1));
            runOp(v, rfwe, re, we, f3, addr, $urandom, $urandom, $urandom_range(0, 5), sp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage RV32I pipeline.
- Consumes the EX/MEM bundle and performs load/store accesses on the data-RAM handshake port.
- Aligns and sign/zero-extends load data.
- Produces the registered write-back bundle (rf_we_wb, wR_wb, wd_sel_wb, alu_c_wb, pc_wb, dram_rd_wb, sext_wb) that drives register-file writes.
- Stalls upstream while a DRAM access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: wait cycles (from first dram_req) with no dram_ack before the access is aborted; must be >=1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_mem  in  1  EX/MEM holds a live instruction
- rf_we_mem  in  1  instruction writes the RF
- wd_sel_mem  in  2  write-back source select, passed through
- wR_mem  in  5  destination register
- alu_c_mem  in  32  ALU result; also the memory address
- rD2_mem  in  32  store data
- pc_mem  in  32  instruction PC
- sext_mem  in  32  sign-extended immediate
- mem_re_mem  in  1  load
- mem_we_mem  in  1  store
- funct3_mem  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- dram_req  out  1  access request
- dram_we  out  1  write request
- dram_addr  out  32  word-aligned address ({alu_c[31:2],2'b00})
- dram_wdata  out  32  lane-replicated store data
- dram_wstrb  out  4  byte strobes
- dram_ack  in  1  access complete; rdata valid this cycle for reads
- dram_rdata  in  32  read word
- stall_mem  out  1  hold IF/ID/EX and EX/MEM registers
- rf_we_wb  out  1  registered RF write enable
- wd_sel_wb  out  2  registered wd_sel
- wR_wb  out  5  registered destination
- alu_c_wb  out  32  registered ALU result
- pc_wb  out  32  registered PC
- sext_wb  out  32  registered immediate
- dram_rd_wb  out  32  registered aligned/extended load data
- misalign_err  out  1  one-cycle pulse: misaligned access rejected
- bus_err  out  1  one-cycle pulse: DRAM timeout

Behaviour:
- Reset (async, rst_n=0): all *_wb outputs 0, state IDLE, timeout counter 0, error pulses 0. Stall and dram outputs are deasserted during reset.
- Access condition: acc = valid_mem & (mem_re_mem | mem_we_mem) & aligned.
- Alignment rules:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=0.
  - B/BU is always aligned.
- FSM states: IDLE, WAIT.
  - IDLE & acc: dram_req=1 combinationally. If dram_ack is seen the same cycle, the access completes with zero stall. Otherwise go to WAIT with stall_mem=1.
  - WAIT: dram_req=1 and stall_mem=1. Request fields stay stable, since upstream is held. On dram_ack, complete and go to IDLE.
  - WAIT, counter reaches TIMEOUT_CYCLES-1 without ack: abort, bus_err=1 for one cycle, go to IDLE. The instruction retires with rf_we_wb=0.
- Completion: the MEM/WB register captures on the completion edge; stall_mem=0 in that cycle.
- Non-memory instruction: the MEM/WB register captures every cycle with no stall; latency is 1 cycle.
- Bubble insertion: while stall_mem=1 the MEM/WB register loads a bubble (rf_we_wb=0) every cycle, so no duplicate RF write occurs.
- Invalid instruction: valid_mem=0 captures rf_we_wb=0.
- Misaligned access:
  - No dram_req.
  - misalign_err pulses for one cycle.
  - Captured with rf_we_wb=0.
  - No stall.
- Load data, lane selected by addr[1:0]:
  - B: sign-extend byte lane addr[1:0].
  - BU: zero-extend byte lane addr[1:0].
  - H: sign-extend halfword lane addr[1].
  - HU: zero-extend halfword lane addr[1].
  - W: full word.
  - Non-load: dram_rd_wb=0.
- Store data and strobes:
  - SB: wdata={4{rD2[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{rD2[15:0]}}, wstrb=0011<<{addr[1],1'b0}.
  - SW: wdata=rD2, wstrb=1111.
  - Loads: wstrb=0000, dram_we=0.
- Load and store both asserted: treated as a store.
- Unsupported funct3 (011, 110, 111) on a memory op: treated as misaligned.
- dram_ack outside IDLE-with-acc or WAIT: ignored.
- Reset mid-WAIT: returns to IDLE immediately; the outstanding access is abandoned (DRAM is reset in the same domain).

Decomposition:
- Shared package pipe_pkg holds:
  - wd_sel encodings: WD_ALU=0, WD_DRAM=1, WD_PC4=2, WD_SEXT=3.
  - funct3 load/store size constants.
  - FSM state enum {IDLE, WAIT}.
- One sub-module, lsu_align: a combinational block that generates wstrb/wdata and extracts and extends load data. The FSM, timeout counter and MEM/WB register stay in mem_wb_stage.

Test Plan:
1. ALU op, valid_mem=1, rf_we_mem=1, wR_mem=5, alu_c=0x1234 -> next cycle rf_we_wb=1, wR_wb=5, alu_c_wb=0x1234; stall_mem never 1.
2. LB at addr 0x103, dram_ack 2 cycles after req, rdata=0x80FFFFFF -> stall_mem high 2 cycles, wb bundle holds bubbles meanwhile, then dram_rd_wb=0xFFFFFF80 with rf_we_wb=1 exactly once.
3. SH at addr 0x202, rD2=0xABCD1234, ack same cycle -> dram_we=1, wstrb=1100, wdata=0x12341234, no stall.
4. LW at addr 0x101 -> no dram_req, misalign_err one-cycle pulse, rf_we_wb=0 next cycle.
5. LW with ack never returned, TIMEOUT_CYCLES=4 -> stall 4 cycles, bus_err pulse, FSM back to IDLE, rf_we_wb=0.
6. rst_n low during WAIT -> all outputs 0 immediately; after release, a new LHU at 0x002 with rdata=0x8001xxxx gives dram_rd_wb=0x00008001.
